// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: FSM encoding, ALU op width,
// the hard-wired zero register index and the EX control bundle layout.
package id_ex_stage_pkg;

  localparam int ALUOP_W = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic reg_dst;
  } ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use compare between the load sitting in EX and the
// instruction currently decoded in ID.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_write_reg_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_mem_write_i,
  input  logic       id_alu_src_i,
  output logic       hazard_o
);

  logic ex_is_load;
  logic rt_match;

  assign ex_is_load = ex_valid_i && ex_mem_read_i && (ex_write_reg_i != REG_ZERO);
  // rt only matters as an operand unless the instruction is a store using an immediate offset
  assign rt_match   = (ex_write_reg_i == id_rt_i) && (!id_mem_write_i || !id_alu_src_i);
  assign hazard_o   = ex_is_load && id_valid_i && ((ex_write_reg_i == id_rs_i) || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass, load-use bubble insertion, downstream hold
// and branch flush. All pipeline state lives here; hazard_detect is purely combinational.
module id_ex_stage #(
  parameter int ALUOP_W = id_ex_stage_pkg::ALUOP_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               IdValid,
  input  logic [4:0]         IdRs,
  input  logic [4:0]         IdRt,
  input  logic [4:0]         IdRd,
  input  logic [31:0]        ReadData1,
  input  logic [31:0]        ReadData2,
  input  logic [31:0]        IdImm,
  input  logic [31:0]        IdPCPlus4,
  input  logic               IdRegWrite,
  input  logic               IdMemRead,
  input  logic               IdMemWrite,
  input  logic               IdMemToReg,
  input  logic               IdALUSrc,
  input  logic               IdRegDst,
  input  logic [ALUOP_W-1:0] IdALUOp,
  input  logic               WbRegWrite,
  input  logic [4:0]         WbWriteRegister,
  input  logic [31:0]        WbWriteData,
  input  logic               ExtStall,
  input  logic               Flush,
  output logic               ExValid,
  output logic [4:0]         ExRs,
  output logic [4:0]         ExRt,
  output logic [4:0]         ExRd,
  output logic [31:0]        ExData1,
  output logic [31:0]        ExData2,
  output logic [31:0]        ExImm,
  output logic [31:0]        ExPCPlus4,
  output logic               ExRegWrite,
  output logic               ExMemRead,
  output logic               ExMemWrite,
  output logic               ExMemToReg,
  output logic               ExALUSrc,
  output logic               ExRegDst,
  output logic [ALUOP_W-1:0] ExALUOp,
  output logic [4:0]         ExWriteReg,
  output logic               HazardStall,
  output logic [7:0]         BubbleCount
);

  import id_ex_stage_pkg::*;

  state_e             state_q, state_d;
  ex_ctrl_t           ctrl_q, ctrl_d, id_ctrl;
  logic               valid_q, valid_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d;
  logic [4:0]         rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, wr_q, wr_d;
  logic [31:0]        d1_q, d1_d, d2_q, d2_d, imm_q, imm_d, pc_q, pc_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               flush_pend_q, flush_pend_d;
  logic               hazard_raw, flush_req, do_hold, do_bubble;
  logic               wb_hit_id_rs, wb_hit_id_rt, wb_hit_ex_rs, wb_hit_ex_rt;

  hazard_detect u_hazard_detect (
    .ex_valid_i     (valid_q),
    .ex_mem_read_i  (ctrl_q.mem_read),
    .ex_write_reg_i (wr_q),
    .id_valid_i     (IdValid),
    .id_rs_i        (IdRs),
    .id_rt_i        (IdRt),
    .id_mem_write_i (IdMemWrite),
    .id_alu_src_i   (IdALUSrc),
    .hazard_o       (hazard_raw)
  );

  // a flush seen during a hold is remembered so it lands on the first free edge
  assign flush_req   = Flush || flush_pend_q;
  assign HazardStall = hazard_raw && !flush_req && !Reset;

  assign wb_hit_id_rs = WbRegWrite && (WbWriteRegister != REG_ZERO) && (WbWriteRegister == IdRs);
  assign wb_hit_id_rt = WbRegWrite && (WbWriteRegister != REG_ZERO) && (WbWriteRegister == IdRt);
  assign wb_hit_ex_rs = WbRegWrite && (WbWriteRegister != REG_ZERO) && (WbWriteRegister == rs_q);
  assign wb_hit_ex_rt = WbRegWrite && (WbWriteRegister != REG_ZERO) && (WbWriteRegister == rt_q);

  always_comb begin
    id_ctrl            = '0;
    id_ctrl.reg_write  = IdRegWrite;
    id_ctrl.mem_read   = IdMemRead;
    id_ctrl.mem_write  = IdMemWrite;
    id_ctrl.mem_to_reg = IdMemToReg;
    id_ctrl.alu_src    = IdALUSrc;
    id_ctrl.reg_dst    = IdRegDst;
    if (!IdValid) id_ctrl = '0;
  end

  always_comb begin
    state_d   = ST_RUN;
    do_hold   = 1'b0;
    do_bubble = 1'b0;
    if (ExtStall) begin
      do_hold = 1'b1;
      state_d = ST_HOLD;
    end else begin
      unique case (state_q)
        ST_RUN, ST_HOLD: do_bubble = flush_req || HazardStall;
        // EX holds a bubble here, so only a flush can extend it
        ST_BUBBLE:       do_bubble = flush_req;
        default:         do_bubble = flush_req || HazardStall;
      endcase
      state_d = do_bubble ? ST_BUBBLE : ST_RUN;
    end
  end

  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    aluop_d      = aluop_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    d1_d         = d1_q;
    d2_d         = d2_q;
    imm_d        = imm_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    flush_pend_d = 1'b0;
    if (do_hold) begin
      flush_pend_d = flush_req;
      if (wb_hit_ex_rs) d1_d = WbWriteData;
      if (wb_hit_ex_rt) d2_d = WbWriteData;
    end else begin
      rs_d  = IdRs;
      rt_d  = IdRt;
      rd_d  = IdRd;
      wr_d  = IdRegDst ? IdRd : IdRt;
      d1_d  = wb_hit_id_rs ? WbWriteData : ReadData1;
      d2_d  = wb_hit_id_rt ? WbWriteData : ReadData2;
      imm_d = IdImm;
      pc_d  = IdPCPlus4;
      if (do_bubble) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
        aluop_d = '0;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end else begin
        valid_d = IdValid;
        ctrl_d  = id_ctrl;
        aluop_d = IdValid ? IdALUOp : '0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_RUN;
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      aluop_q      <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      aluop_q      <= aluop_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      imm_q        <= imm_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign ExValid     = valid_q;
  assign ExRs        = rs_q;
  assign ExRt        = rt_q;
  assign ExRd        = rd_q;
  assign ExData1     = d1_q;
  assign ExData2     = d2_q;
  assign ExImm       = imm_q;
  assign ExPCPlus4   = pc_q;
  assign ExRegWrite  = ctrl_q.reg_write;
  assign ExMemRead   = ctrl_q.mem_read;
  assign ExMemWrite  = ctrl_q.mem_write;
  assign ExMemToReg  = ctrl_q.mem_to_reg;
  assign ExALUSrc    = ctrl_q.alu_src;
  assign ExRegDst    = ctrl_q.reg_dst;
  assign ExALUOp     = aluop_q;
  assign ExWriteReg  = wr_q;
  assign BubbleCount = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a per-cycle reference model of the EX register
// plus hand-computed expectations at each scenario step.
module tb_id_ex_stage;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset, IdValid;
  logic [4:0]  IdRs, IdRt, IdRd;
  logic [31:0] ReadData1, ReadData2, IdImm, IdPCPlus4;
  logic        IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg, IdALUSrc, IdRegDst;
  logic [3:0]  IdALUOp;
  logic        WbRegWrite;
  logic [4:0]  WbWriteRegister;
  logic [31:0] WbWriteData;
  logic        ExtStall, Flush;
  logic        ExValid;
  logic [4:0]  ExRs, ExRt, ExRd, ExWriteReg;
  logic [31:0] ExData1, ExData2, ExImm, ExPCPlus4;
  logic        ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, ExALUSrc, ExRegDst;
  logic [3:0]  ExALUOp;
  logic        HazardStall;
  logic [7:0]  BubbleCount;

  id_ex_stage #(.ALUOP_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .IdValid(IdValid), .IdRs(IdRs), .IdRt(IdRt), .IdRd(IdRd),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .IdImm(IdImm), .IdPCPlus4(IdPCPlus4),
    .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead), .IdMemWrite(IdMemWrite),
    .IdMemToReg(IdMemToReg), .IdALUSrc(IdALUSrc), .IdRegDst(IdRegDst), .IdALUOp(IdALUOp),
    .WbRegWrite(WbRegWrite), .WbWriteRegister(WbWriteRegister), .WbWriteData(WbWriteData),
    .ExtStall(ExtStall), .Flush(Flush), .ExValid(ExValid), .ExRs(ExRs), .ExRt(ExRt),
    .ExRd(ExRd), .ExData1(ExData1), .ExData2(ExData2), .ExImm(ExImm), .ExPCPlus4(ExPCPlus4),
    .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite),
    .ExMemToReg(ExMemToReg), .ExALUSrc(ExALUSrc), .ExRegDst(ExRegDst), .ExALUOp(ExALUOp),
    .ExWriteReg(ExWriteReg), .HazardStall(HazardStall), .BubbleCount(BubbleCount)
  );

  // control vector order: RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst
  localparam logic [5:0] CT_LW  = 6'b110110;
  localparam logic [5:0] CT_ALU = 6'b100001;
  localparam logic [5:0] CT_SW  = 6'b001010;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model of what EX must hold
  logic        e_valid, e_pend, e_known;
  logic [5:0]  e_ctrl;
  logic [3:0]  e_aluop;
  logic [4:0]  e_rs, e_rt, e_rd, e_wr;
  logic [31:0] e_d1, e_d2, e_imm, e_pc;
  int          e_cnt;

  function automatic logic wb_writes(input logic [4:0] r);
    return WbRegWrite && (r != 5'd0) && (WbWriteRegister == r);
  endfunction

  function automatic logic exp_hazard();
    logic ex_load;
    if (Reset || Flush || e_pend) return 1'b0;
    ex_load = e_valid && e_ctrl[4] && (e_wr != 5'd0);
    if (!ex_load || !IdValid) return 1'b0;
    if (e_wr == IdRs) return 1'b1;
    return (e_wr == IdRt) && !(IdMemWrite && IdALUSrc);
  endfunction

  always @(posedge Clk) begin
    logic hz;
    hz = exp_hazard();
    if (Reset) begin
      e_valid = 0; e_pend = 0; e_known = 1; e_ctrl = 0; e_aluop = 0; e_cnt = 0;
      e_rs = 0; e_rt = 0; e_rd = 0; e_wr = 0; e_d1 = 0; e_d2 = 0; e_imm = 0; e_pc = 0;
    end else if (ExtStall) begin
      if (Flush) e_pend = 1;
      if (wb_writes(e_rs)) e_d1 = WbWriteData;
      if (wb_writes(e_rt)) e_d2 = WbWriteData;
    end else if (Flush || e_pend || hz) begin
      e_valid = 0; e_ctrl = 0; e_aluop = 0; e_known = 0; e_pend = 0;
      e_cnt = (e_cnt < 255) ? e_cnt + 1 : 255;
    end else begin
      e_valid = IdValid;
      e_ctrl  = IdValid ? {IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg, IdALUSrc, IdRegDst} : 6'b0;
      e_aluop = IdValid ? IdALUOp : 4'd0;
      e_rs = IdRs; e_rt = IdRt; e_rd = IdRd;
      e_wr = IdRegDst ? IdRd : IdRt;
      e_d1 = wb_writes(IdRs) ? WbWriteData : ReadData1;
      e_d2 = wb_writes(IdRt) ? WbWriteData : ReadData2;
      e_imm = IdImm; e_pc = IdPCPlus4; e_known = 1;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("m_valid", ExValid, e_valid);
      chk("m_ctrl", {ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, ExALUSrc, ExRegDst}, e_ctrl);
      chk("m_aluop", ExALUOp, e_aluop);
      chk("m_bubbles", BubbleCount, e_cnt);
      chk("m_hazard", HazardStall, exp_hazard());
      if (e_known) begin
        chk("m_rs", ExRs, e_rs);
        chk("m_rt", ExRt, e_rt);
        chk("m_rd", ExRd, e_rd);
        chk("m_wr", ExWriteReg, e_wr);
        chk("m_d1", ExData1, e_d1);
        chk("m_d2", ExData2, e_d2);
        chk("m_imm", ExImm, e_imm);
        chk("m_pc", ExPCPlus4, e_pc);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic id_clear();
    IdValid = 0; IdRs = 0; IdRt = 0; IdRd = 0; ReadData1 = 0; ReadData2 = 0;
    IdImm = 0; IdPCPlus4 = 0; IdALUOp = 0;
    {IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg, IdALUSrc, IdRegDst} = 6'b0;
  endtask

  task automatic id_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                          input logic [31:0] pc, input logic [5:0] ctrl, input logic [3:0] op);
    IdValid = 1; IdRs = rs; IdRt = rt; IdRd = rd; ReadData1 = r1; ReadData2 = r2;
    IdImm = imm; IdPCPlus4 = pc; IdALUOp = op;
    {IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg, IdALUSrc, IdRegDst} = ctrl;
  endtask

  initial begin
    id_clear();
    WbRegWrite = 0; WbWriteRegister = 0; WbWriteData = 0;
    // reset wins over a simultaneous stall and flush
    Reset = 1; ExtStall = 1; Flush = 1;
    id_instr(5'd3, 5'd4, 5'd5, 32'h1, 32'h2, 32'h3, 32'h4, CT_LW, 4'h1);
    #1 chk("hz_in_reset", HazardStall, 1'b0);
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_valid", ExValid, 1'b0);
    chk("rst_bubbles", BubbleCount, 8'd0);
    chk("rst_data1", ExData1, 32'h0);
    Reset = 0; ExtStall = 0; Flush = 0;
    id_clear();
    #1 chk("hz_after_reset", HazardStall, 1'b0);

    // plain capture, RegDst selects rd
    id_instr(5'd8, 5'd3, 5'd4, 32'h11, 32'h22, 32'h100, 32'h4, CT_ALU, 4'h2);
    tick();
    chk("cap_data1", ExData1, 32'h11);
    chk("cap_valid", ExValid, 1'b1);
    chk("cap_wr_rd", ExWriteReg, 5'd4);
    chk("cap_aluop", ExALUOp, 4'h2);

    // WB bypass onto rt, then register 0 never bypassed
    id_instr(5'd1, 5'd9, 5'd5, 32'h31, 32'h0, 32'h0, 32'h8, CT_ALU, 4'h3);
    WbRegWrite = 1; WbWriteRegister = 5'd9; WbWriteData = 32'h25;
    tick();
    chk("byp_data2", ExData2, 32'h25);
    chk("byp_data1", ExData1, 32'h31);
    IdRt = 5'd0; ReadData2 = 32'h0; WbWriteRegister = 5'd0; WbWriteData = 32'h99;
    tick();
    chk("byp_r0", ExData2, 32'h0);
    WbRegWrite = 0;

    // invalid instruction: controls stored as zero, RegDst=0 selects rt
    id_instr(5'd2, 5'd7, 5'd6, 32'h0, 32'h0, 32'h0, 32'hC, CT_LW, 4'h5);
    IdValid = 0;
    tick();
    chk("inv_memread", ExMemRead, 1'b0);
    chk("inv_valid", ExValid, 1'b0);
    chk("inv_wr_rt", ExWriteReg, 5'd7);

    // load-use: one bubble then the consumer enters EX
    id_instr(5'd2, 5'd10, 5'd0, 32'h40, 32'h0, 32'h8, 32'h10, CT_LW, 4'h0);
    tick();
    chk("lw_wr", ExWriteReg, 5'd10);
    id_instr(5'd10, 5'd3, 5'd11, 32'hA, 32'hB, 32'h0, 32'h14, CT_ALU, 4'h1);
    #1 chk("lu_hazard", HazardStall, 1'b1);
    tick();
    chk("lu_bubble", ExValid, 1'b0);
    chk("lu_count", BubbleCount, 8'd1);
    chk("lu_hz_clear", HazardStall, 1'b0);
    tick();
    chk("lu_enter", ExValid, 1'b1);
    chk("lu_enter_rs", ExRs, 5'd10);
    chk("lu_enter_rd", ExRd, 5'd11);

    // store with immediate offset does not stall on rt
    id_instr(5'd2, 5'd13, 5'd0, 32'h0, 32'h0, 32'h4, 32'h18, CT_LW, 4'h0);
    tick();
    id_instr(5'd1, 5'd13, 5'd0, 32'h0, 32'h0, 32'h4, 32'h1C, CT_SW, 4'h0);
    #1 chk("sw_no_hazard", HazardStall, 1'b0);
    tick();
    chk("sw_enter", ExMemWrite, 1'b1);
    chk("sw_count", BubbleCount, 8'd1);

    // hold for three cycles while WB refreshes the held rs operand
    id_instr(5'd12, 5'd4, 5'd0, 32'h5, 32'h6, 32'h1234, 32'h20, CT_ALU, 4'h3);
    tick();
    chk("hold_pre", ExData1, 32'h5);
    ExtStall = 1;
    id_instr(5'd20, 5'd21, 5'd22, 32'hDEAD, 32'hBEEF, 32'h55, 32'h24, CT_LW, 4'h7);
    WbRegWrite = 1; WbWriteRegister = 5'd12; WbWriteData = 32'h77;
    tick();
    WbRegWrite = 0;
    tick();
    tick();
    chk("hold_rs", ExRs, 5'd12);
    chk("hold_data1", ExData1, 32'h77);
    chk("hold_data2", ExData2, 32'h6);
    chk("hold_imm", ExImm, 32'h1234);
    chk("hold_pc", ExPCPlus4, 32'h20);
    chk("hold_aluop", ExALUOp, 4'h3);
    ExtStall = 0;
    tick();
    chk("hold_release", ExRs, 5'd20);

    // flush coincident with a load-use hazard gives one bubble only
    id_instr(5'd2, 5'd10, 5'd0, 32'h0, 32'h0, 32'h0, 32'h28, CT_LW, 4'h0);
    tick();
    id_instr(5'd10, 5'd3, 5'd11, 32'h0, 32'h0, 32'h0, 32'h2C, CT_ALU, 4'h1);
    Flush = 1;
    #1 chk("fl_hz_masked", HazardStall, 1'b0);
    tick();
    chk("fl_bubble", ExValid, 1'b0);
    chk("fl_count", BubbleCount, 8'd2);
    Flush = 0;
    tick();
    chk("fl_next", ExValid, 1'b1);

    // flush under hold lands after release
    Flush = 1; ExtStall = 1;
    tick();
    chk("flh_held", ExValid, 1'b1);
    chk("flh_count", BubbleCount, 8'd2);
    ExtStall = 0;
    tick();
    chk("flh_bubble", ExValid, 1'b0);
    chk("flh_count2", BubbleCount, 8'd3);
    Flush = 0;

    // reset while a load-use bubble sits in EX
    id_instr(5'd2, 5'd10, 5'd0, 32'h0, 32'h0, 32'h0, 32'h30, CT_LW, 4'h0);
    tick();
    id_instr(5'd10, 5'd3, 5'd11, 32'h9, 32'h0, 32'h0, 32'h34, CT_ALU, 4'h1);
    tick();
    chk("rb_bubble", BubbleCount, 8'd4);
    Reset = 1;
    tick();
    chk("rb_valid", ExValid, 1'b0);
    chk("rb_count", BubbleCount, 8'd0);
    chk("rb_rs", ExRs, 5'd0);
    chk("rb_imm", ExImm, 32'h0);
    Reset = 0;
    tick();
    chk("rb_no_residual", ExValid, 1'b1);
    chk("rb_data1", ExData1, 32'h9);

    // saturation of the bubble counter
    Flush = 1;
    for (int i = 0; i < 256; i++) tick();
    chk("sat_256", BubbleCount, 8'd255);
    tick();
    chk("sat_257", BubbleCount, 8'd255);
    Flush = 0;
    id_clear();
    tick();
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one parameter: ALUOP_W, default 4, ALU operation code width.
REQ-002 The block SHALL have port Clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1, reset that is synchronous and active-high.
REQ-004 The block SHALL have the ID inputs IdValid 1; IdRs 5; IdRt 5; IdRd 5; ReadData1 32; ReadData2 32 (register-file read ports); IdImm 32 (sign-extended immediate); IdPCPlus4 32.
REQ-005 The block SHALL have the ID control inputs IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg, IdALUSrc, IdRegDst (1 each) and IdALUOp (ALUOP_W).
REQ-006 The block SHALL have the write-back inputs WbRegWrite 1, WbWriteRegister 5, WbWriteData 32, the same values driven into the register file this cycle.
REQ-007 The block SHALL have the control inputs ExtStall 1 (downstream hold) and Flush 1 (branch squash).
REQ-008 The block SHALL have the outputs ExValid 1, ExRs/ExRt/ExRd 5, ExData1/ExData2 32, ExImm 32, ExPCPlus4 32, all Ex* control copies, and ExWriteReg 5.
REQ-009 The block SHALL have the outputs HazardStall 1 (freeze PC and IF/ID) and BubbleCount 8 (saturating bubble-insertion counter).

Function
REQ-010 The EX register SHALL capture all Id* fields on each rising edge unless held or bubbled; latency ID to EX is 1 cycle.
REQ-011 WB bypass: if WbRegWrite=1, WbWriteRegister!=0 and WbWriteRegister==IdRs, then ExData1 SHALL capture WbWriteData instead of ReadData1; the same rule applies to IdRt/ExData2.
REQ-012 Register 0 SHALL never be bypassed; data captured for IdRs=0 or IdRt=0 is ReadData as given (expected 0).
REQ-013 ExWriteReg SHALL be IdRd when IdRegDst=1, otherwise IdRt, registered with the rest.
REQ-014 Load-use hazard: HazardStall SHALL be combinationally 1 when ExValid=1, ExMemRead=1, ExWriteReg!=0, IdValid=1 and ExWriteReg equals IdRs, or equals IdRt with IdMemWrite=0 or IdALUSrc=0.
REQ-015 While HazardStall=1 and ExtStall=0, the next edge SHALL load a bubble: ExValid=0 and all Ex* control bits 0, with data fields don't-care.
REQ-016 The FSM SHALL have states RUN, BUBBLE and HOLD.
REQ-017 RUN->BUBBLE SHALL occur on HazardStall.
REQ-018 BUBBLE->RUN SHALL occur after exactly one bubble cycle.
REQ-019 Any state->HOLD SHALL occur on ExtStall=1; HOLD->RUN SHALL occur when ExtStall=0.
REQ-020 In HOLD, every Ex* register SHALL retain its value, but the WB bypass SHALL still update a held ExData1/ExData2 whose ExRs/ExRt matches a WB write, so held operands never go stale.
REQ-021 Flush=1 SHALL load a bubble on the next edge and override HazardStall.
REQ-022 ExtStall SHALL have priority over Flush; the flush is applied on the first non-held edge.
REQ-023 HazardStall SHALL be forced to 0 while Flush=1.
REQ-024 BubbleCount SHALL increment on every bubble loaded (hazard or flush) and saturate at 255.
REQ-025 The control fields of an IdValid=0 input SHALL be stored as zeros.

Reset
REQ-026 With Reset=1 at a rising edge, ExValid and all Ex* control bits SHALL become 0, and ExRs/ExRt/ExRd/ExWriteReg, ExData1/2, ExImm, ExPCPlus4 and BubbleCount SHALL become 0.
REQ-027 Reset SHALL put the FSM in RUN.
REQ-028 Reset SHALL override ExtStall, Flush and hazard, and may occur mid-stall with no residual bubble after release.
REQ-029 HazardStall SHALL be 0 during and on the first cycle after reset.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, ALUOP_W, the register-0 constant and the EX control bundle layout.
REQ-031 A sub-module hazard_detect SHALL contain the combinational load-use compare of REQ-014; all registers SHALL reside in id_ex_stage.

Verification
REQ-032 Reset then IdValid=1, IdRs=8, ReadData1=0x11 -> one cycle later ExData1=0x11, ExValid=1.
REQ-033 WbRegWrite=1, WbWriteRegister=9, WbWriteData=0x25, IdRt=9, ReadData2=0x0 -> ExData2=0x25; repeat with register 0 -> ExData2=ReadData2.
REQ-034 EX holds lw to reg 10; ID reads IdRs=10 -> HazardStall=1 for one cycle, next ExValid=0, BubbleCount=1, then the instruction enters EX.
REQ-035 ExtStall=1 for 3 cycles while a WB write to ExRs=12 of 0x77 occurs -> Ex* fields frozen except ExData1=0x77; release resumes.
REQ-036 Flush=1 coincident with the hazard -> single bubble, HazardStall=0, BubbleCount+1; Flush with ExtStall=1 -> bubble after release.
REQ-037 Reset asserted in BUBBLE -> all outputs 0 next edge, and 256 bubbles -> BubbleCount stays 255.
